periph_xbar: RTL and testbench
==============================

Name: periph_xbar

Overview:
Parametrised successor to the fixed peripheral bus. It is a registered MMIO interconnect between the CPU data port and up to NUM_SLOTS peripheral slots, decoded on addr[11:8]. It adds a transaction FSM with wait-state tracking, a per-access timeout watchdog, decode/timeout bus errors, and an internal error-status register bank that raises an error interrupt. Interrupt-controller wiring stays outside this block.

Parameters:
NUM_SLOTS, 4, number of slave slots (1..14); slot k is decoded when addr[11:8]==k.
TIMEOUT, 255, max wait cycles in ACTIVE before the access is aborted (1..65535).
ERR_SLOT, 4'hE, addr[11:8] value of the internal error register bank; must be >= NUM_SLOTS.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
addr  in  16  CPU address
sel  in  1  CPU peripheral-space select
we  in  1  write strobe
re  in  1  read strobe
wdata  in  16  write data
rdata  out  16  read data; valid while rdy=1
rdy  out  1  one-cycle completion pulse
err  out  1  access failed; valid with rdy
s_sel  out  NUM_SLOTS  one-hot slave select
s_we  out  1  latched write strobe to slaves
s_re  out  1  latched read strobe to slaves
s_addr  out  8  latched addr[7:0]
s_wdata  out  16  latched write data
s_rdata  in  16*NUM_SLOTS  slave read data; slot k at [16k+15:16k]
s_rdy  in  NUM_SLOTS  slave ready
err_irq  out  1  level interrupt; high while ERRSTAT[1:0] != 0

Behaviour:
- Registered outputs. Reset value of every output is 0. FSM state, timer and error registers also reset to 0 (state = IDLE).
- The FSM has three states: IDLE, ACTIVE and RESP.
- IDLE: when sel && (we||re), latch addr, wdata, we and re. Then take one of three paths:
  - addr[11:8] < NUM_SLOTS: go to ACTIVE, set s_sel bit addr[11:8], clear the timer.
  - addr[11:8] == ERR_SLOT: perform the internal register access and go to RESP with err=0.
  - Any other addr[11:8]: decode error. Go to RESP with err=1 and rdata=0.
  - If sel is high with we=re=0, ignore it.
- ACTIVE: s_sel, s_we, s_re, s_addr and s_wdata are held stable.
  - If s_rdy[slot]=1: capture the slot's s_rdata (0 on writes) and go to RESP with err=0.
  - Else, if the timer == TIMEOUT-1: go to RESP with err=1 and rdata=0.
  - Else: increment the timer.
  - s_sel drops in the same edge that enters RESP.
- RESP: rdy=1 for exactly one cycle, then return to IDLE. A new request is accepted in IDLE on the cycle after RESP. The master drops or changes its request on the cycle after rdy.
- Minimum latency: with a zero-wait slave, rdy rises 2 cycles after the request is first sampled. Internal and decode-error accesses complete in 1 cycle.
- Slave s_rdy outside ACTIVE, or on an unselected slot, is ignored.
- ERRSTAT is at offset addr[3:1]=0:
  - bit0 = decode error
  - bit1 = timeout
  - bit2 = overflow (an error occurred while bit0 or bit1 was already set)
  - bits[7:4] = slot field (addr[11:8]) of the first error
  - all other bits are 0
- ERRADDR is at offset addr[3:1]=1 and holds the full 16-bit address of the first error.
- First-error capture is sticky: later errors set only bit2.
- Writing any value to ERRSTAT clears ERRSTAT and ERRADDR. If a clear and a new error coincide, the clear wins (the two cannot coincide, because accesses are serialised).
- ERRADDR is read-only; writes to it are ignored. Other offsets read 0.
- err_irq = ERRSTAT[0] | ERRSTAT[1].
- Reset mid-access (async): s_sel drops immediately, the FSM goes to IDLE, no rdy is produced, and the error registers are cleared.
- Timer width is clog2(TIMEOUT+1). The timer saturates and never wraps.

Test Plan:
- Read slot 1 at 0x8102, slot rdy immediate with data 0xBEEF -> s_sel=0010, s_addr=0x02, rdata=0xBEEF, rdy 2 cycles after the request, err=0.
- Write 0x1234 to slot 0, s_rdy delayed 5 cycles -> s_wdata=0x1234 held for 6 ACTIVE cycles, single rdy pulse, err=0.
- Read 0x8900 with NUM_SLOTS=4 -> rdy after 1 cycle, err=1, rdata=0. Then ERRSTAT reads 0x0091, ERRADDR reads 0x8900, err_irq=1.
- Slot 2 never ready, TIMEOUT=8 -> err=1 after 8 ACTIVE cycles, s_sel cleared, ERRSTAT=0x0022. A second timeout gives ERRSTAT=0x0026.
- Write 0 to 0x8E00 -> ERRSTAT=0, ERRADDR=0, err_irq=0.
- Assert rst during ACTIVE -> s_sel=0 and rdy=0 immediately. After release, a normal read succeeds.

Source files
------------

// File: rtl/periph_xbar.sv
`default_nettype none
// ============================================================================
// Module   : periph_xbar
// Purpose  : Registered MMIO crossbar from the CPU data port to NUM_SLOTS
//            peripheral slots, with a wait-state watchdog and error register bank.
// Revision : 1.0 - initial release
// ============================================================================
module periph_xbar #(
    parameter int         NUM_SLOTS = 4,
    parameter int         TIMEOUT   = 255,
    parameter logic [3:0] ERR_SLOT  = 4'hE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               addr,
    input  logic                      sel,
    input  logic                      we,
    input  logic                      re,
    input  logic [15:0]               wdata,
    output logic [15:0]               rdata,
    output logic                      rdy,
    output logic                      err,
    output logic [NUM_SLOTS-1:0]      s_sel,
    output logic                      s_we,
    output logic                      s_re,
    output logic [7:0]                s_addr,
    output logic [15:0]               s_wdata,
    input  logic [16*NUM_SLOTS-1:0]   s_rdata,
    input  logic [NUM_SLOTS-1:0]      s_rdy,
    output logic                      err_irq
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [4:0]    N_SLOTS = 5'(NUM_SLOTS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          timer_q;
    logic [15:0]            addr_q;
    logic                   we_q;
    logic [NUM_SLOTS-1:0]   s_sel_q;
    logic                   s_we_q;
    logic                   s_re_q;
    logic [7:0]             s_addr_q;
    logic [15:0]            s_wdata_q;
    logic [15:0]            rdata_q;
    logic                   rdy_q;
    logic                   err_q;
    logic [7:0]             errstat_q;
    logic [7:0]             errstat_d;
    logic [15:0]            erraddr_q;
    logic [15:0]            erraddr_d;
    logic                   err_irq_q;

    logic                   w_req;
    logic [3:0]             w_field;
    logic                   w_is_slot;
    logic                   w_is_int;
    logic [NUM_SLOTS-1:0]   w_dec_oh;
    logic                   w_slot_hit;
    logic [15:0]            w_slot_data;
    logic                   w_timeout;
    logic                   w_dec_err;
    logic                   w_clr;
    logic [15:0]            w_int_rd;
    logic [15:0]            w_err_addr;

    assign w_req     = sel & (we | re);
    assign w_field   = addr[11:8];
    assign w_is_slot = ({1'b0, w_field} < N_SLOTS);
    assign w_is_int  = (w_field == ERR_SLOT);

    always_comb begin
        w_dec_oh = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_dec_oh[k] = (w_field == 4'(k));
        end
    end

    // s_sel_q is one-hot, so an AND-OR mux picks the active slot's data.
    always_comb begin
        w_slot_data = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (s_sel_q[k]) begin
                w_slot_data = w_slot_data | s_rdata[16*k +: 16];
            end
        end
    end

    assign w_slot_hit = |(s_rdy & s_sel_q);
    assign w_timeout  = (state_q == ST_ACTIVE) && !w_slot_hit && (timer_q == T_LAST);
    assign w_dec_err  = (state_q == ST_IDLE) && w_req && !w_is_slot && !w_is_int;
    assign w_clr      = (state_q == ST_IDLE) && w_req && !w_is_slot && w_is_int
                        && we && (addr[3:1] == 3'd0);
    assign w_err_addr = w_timeout ? addr_q : addr;

    always_comb begin
        case (addr[3:1])
            3'd0:    w_int_rd = {8'h00, errstat_q};
            3'd1:    w_int_rd = erraddr_q;
            default: w_int_rd = 16'h0000;
        endcase
    end

    // Only the first error is recorded; later ones just flag overflow.
    always_comb begin
        errstat_d = errstat_q;
        erraddr_d = erraddr_q;
        if (w_clr) begin
            errstat_d = 8'h00;
            erraddr_d = 16'h0000;
        end else if (w_dec_err || w_timeout) begin
            if (errstat_q[1:0] != 2'b00) begin
                errstat_d[2] = 1'b1;
            end else begin
                errstat_d = {w_err_addr[11:8], 1'b0, 1'b0, w_timeout, w_dec_err};
                erraddr_d = w_err_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            s_sel_q   <= '0;
            s_we_q    <= 1'b0;
            s_re_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            rdata_q   <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            errstat_q <= '0;
            erraddr_q <= '0;
            err_irq_q <= 1'b0;
        end else begin
            rdy_q     <= 1'b0;
            errstat_q <= errstat_d;
            erraddr_q <= erraddr_d;
            err_irq_q <= |errstat_d[1:0];
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        addr_q    <= addr;
                        we_q      <= we;
                        s_addr_q  <= addr[7:0];
                        s_wdata_q <= wdata;
                        if (w_is_slot) begin
                            state_q <= ST_ACTIVE;
                            s_sel_q <= w_dec_oh;
                            s_we_q  <= we;
                            s_re_q  <= re;
                            timer_q <= '0;
                        end else if (w_is_int) begin
                            state_q <= ST_RESP;
                            rdy_q   <= 1'b1;
                            err_q   <= 1'b0;
                            rdata_q <= we ? 16'h0000 : w_int_rd;
                        end else begin
                            state_q <= ST_RESP;
                            rdy_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 16'h0000;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_slot_hit || (timer_q == T_LAST)) begin
                        state_q <= ST_RESP;
                        rdy_q   <= 1'b1;
                        err_q   <= !w_slot_hit;
                        rdata_q <= (w_slot_hit && !we_q) ? w_slot_data : 16'h0000;
                        s_sel_q <= '0;
                        s_we_q  <= 1'b0;
                        s_re_q  <= 1'b0;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b0;
                    rdata_q <= 16'h0000;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign rdy     = rdy_q;
    assign err     = err_q;
    assign s_sel   = s_sel_q;
    assign s_we    = s_we_q;
    assign s_re    = s_re_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign err_irq = err_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_periph_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_periph_xbar
// Purpose  : Scoreboard bench for periph_xbar with behavioural slaves and model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_periph_xbar;

    localparam int NS = 4;
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [15:0]          addr, wdata, rdata, s_wdata;
    logic                 sel, we, re, rdy, err, s_we, s_re, err_irq;
    logic [NS-1:0]        s_sel, s_rdy;
    logic [7:0]           s_addr;
    logic [16*NS-1:0]     s_rdata;

    periph_xbar #(.NUM_SLOTS(NS), .TIMEOUT(TO), .ERR_SLOT(4'hE)) dut (
        .clk(clk), .rst(rst), .addr(addr), .sel(sel), .we(we), .re(re),
        .wdata(wdata), .rdata(rdata), .rdy(rdy), .err(err), .s_sel(s_sel),
        .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_rdy(s_rdy), .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] ref_mem [NS][256];
    logic [15:0] slv_mem [NS][256];
    bit          m_dec, m_to, m_ovf;
    logic [3:0]  m_slot;
    logic [15:0] m_eaddr;

    logic [NS-1:0] exp_sel;
    logic [7:0]    exp_saddr;
    logic [15:0]   exp_wdata;
    logic          exp_we, exp_re;
    int            slv_lat;
    int            act_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_errstat();
        return {8'h00, m_slot, 1'b0, m_ovf, m_to, m_dec};
    endfunction

    function automatic void m_clear();
        m_dec = 0; m_to = 0; m_ovf = 0; m_slot = 4'h0; m_eaddr = 16'h0000;
    endfunction

    function automatic void m_log(input bit is_to, input logic [15:0] a);
        if (m_dec || m_to) m_ovf = 1;
        else begin
            m_dec = !is_to; m_to = is_to; m_slot = a[11:8]; m_eaddr = a;
        end
    endfunction

    task automatic do_req(input logic [15:0] a, input bit w, input logic [15:0] d, input int lat);
        exp_t e;
        int   cyc;
        int   exp_cyc;
        int   slot;
        bit   active;
        slot   = int'(a[11:8]);
        e      = '0;
        active = 0;
        if (slot < NS) begin
            active = 1;
            if (lat >= TO) begin
                e.err = 1; m_log(1, a); exp_cyc = TO + 1;
            end else begin
                exp_cyc = lat + 2;
                if (w) ref_mem[slot][a[7:0]] = d;
                else   e.rdata = ref_mem[slot][a[7:0]];
            end
        end else if (slot == 14) begin
            exp_cyc = 1;
            if (a[3:1] == 3'd0) begin
                if (w) m_clear(); else e.rdata = m_errstat();
            end else if (a[3:1] == 3'd1 && !w) begin
                e.rdata = m_eaddr;
            end
        end else begin
            exp_cyc = 1; e.err = 1; m_log(0, a);
        end
        e.irq = m_dec | m_to;
        sb.push_back(e);
        exp_sel   = active ? NS'(1 << slot) : '0;
        exp_saddr = a[7:0];
        exp_wdata = d;
        exp_we    = w;
        exp_re    = !w;
        slv_lat   = lat;
        act_cyc   = 0;
        @(negedge clk);
        addr = a; sel = 1'b1; we = w; re = !w; wdata = d;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!rdy && cyc < 40);
        chk("latency", cyc, exp_cyc);
        sel = 1'b0; we = 1'b0; re = 1'b0;
        if (active) chk("active_cycles", act_cyc, (lat >= TO) ? TO : lat + 1);
        @(posedge clk); #1;
        chk("rdy_single_pulse", rdy, 1'b0);
    endtask

    // Behavioural slaves: selected slot answers after slv_lat wait cycles,
    // every other s_rdy bit and unselected data lane carries noise.
    initial begin
        int scnt;
        int k;
        s_rdy = '0; s_rdata = '0; scnt = 0;
        forever begin
            @(negedge clk);
            if (s_sel != '0) begin
                k = 0;
                for (int i = 0; i < NS; i++) if (s_sel[i]) k = i;
                chk("slave_bus", {s_sel, s_addr, s_wdata, s_we, s_re},
                    {exp_sel, exp_saddr, exp_wdata, exp_we, exp_re});
                act_cyc++;
                if (scnt == slv_lat) begin
                    s_rdy = s_sel | (NS'($urandom) & ~s_sel);
                    if (s_we) slv_mem[k][s_addr] = s_wdata;
                end else begin
                    s_rdy = NS'($urandom) & ~s_sel;
                end
                scnt++;
            end else begin
                scnt  = 0;
                s_rdy = NS'($urandom);
            end
            for (int i = 0; i < NS; i++)
                s_rdata[16*i +: 16] = s_sel[i] ? slv_mem[i][s_addr] : 16'($urandom);
        end
    end

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rdy: got rdy=1 with rdata %h, expected no response", rdata);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.rdata);
                    chk("err", err, e.err);
                    chk("err_irq", err_irq, e.irq);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int          r, f;
        for (int s = 0; s < NS; s++)
            for (int j = 0; j < 256; j++) begin
                ref_mem[s][j] = 16'h0000; slv_mem[s][j] = 16'h0000;
            end
        m_clear();
        slv_lat = 0; act_cyc = 0;
        exp_sel = '0; exp_saddr = '0; exp_wdata = '0; exp_we = 0; exp_re = 0;
        rst = 1'b1; addr = '0; sel = 0; we = 0; re = 0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {rdata, rdy, err, s_sel, s_we, s_re, s_addr, s_wdata, err_irq}, '0);
        @(negedge clk); rst = 1'b0;

        ref_mem[1][8'h02] = 16'hBEEF; slv_mem[1][8'h02] = 16'hBEEF;
        do_req(16'h8102, 0, 16'h0000, 0);
        do_req(16'h8000, 1, 16'h1234, 5);
        do_req(16'h8000, 0, 16'h0000, 1);
        do_req(16'h8900, 0, 16'h0000, 0);
        do_req(16'h8E00, 0, 16'h0000, 0);
        do_req(16'h8E02, 0, 16'h0000, 0);
        do_req(16'h8E00, 1, 16'h0000, 0);
        do_req(16'h8E00, 0, 16'h0000, 0);
        do_req(16'h8E02, 0, 16'h0000, 0);
        do_req(16'h8200, 0, 16'h0000, 255);
        do_req(16'h8E00, 0, 16'h0000, 0);
        do_req(16'h8210, 0, 16'h0000, 255);
        do_req(16'h8E00, 0, 16'h0000, 0);
        do_req(16'h8E02, 1, 16'hFFFF, 0);
        do_req(16'h8E02, 0, 16'h0000, 0);
        do_req(16'h8E00, 1, 16'hFFFF, 0);
        do_req(16'h8333, 1, 16'h5A5A, TO - 1);
        do_req(16'h8333, 0, 16'h0000, TO - 1);

        @(negedge clk); sel = 1'b1; we = 0; re = 0; addr = 16'h8100;
        repeat (4) begin
            @(posedge clk); #1;
            chk("idle_no_strobe", {rdy, s_sel}, '0);
        end
        sel = 1'b0;

        do_req(16'h8F00, 0, 16'h0000, 0);
        exp_sel = 4'b1000; exp_saddr = 8'h44; exp_wdata = 16'h0000;
        exp_we = 0; exp_re = 1; slv_lat = 255;
        @(negedge clk); addr = 16'h8344; sel = 1'b1; re = 1'b1; wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", {s_sel, rdy, err_irq}, '0);
        m_clear();
        sel = 1'b0; re = 1'b0;
        @(negedge clk); rst = 1'b0;
        do_req(16'h8E00, 0, 16'h0000, 0);
        do_req(16'h8102, 0, 16'h0000, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                a = {4'($urandom), 4'($urandom_range(0, NS - 1)), 8'($urandom)};
                f = $urandom_range(0, 9);
                do_req(a, 1'($urandom), 16'($urandom),
                       (f == 9) ? 255 : (f == 8) ? TO - 1 : $urandom_range(0, 4));
            end else if (r < 9) begin
                a = {4'($urandom), 4'hE, 4'($urandom), 3'($urandom_range(0, 3)), 1'($urandom)};
                do_req(a, ($urandom_range(0, 3) == 0), 16'($urandom), 0);
            end else begin
                f = $urandom_range(NS, 14);
                if (f == 14) f = 15;
                a = {4'($urandom), 4'(f), 8'($urandom)};
                do_req(a, 1'($urandom), 16'($urandom), 0);
            end
        end

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
